// File: rtl/mem_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_pkg
// Shared processor package for the instruction/data memory port arbiter.
// Holds the arbiter FSM state encoding, the requester (grant) constants and
// the width of the wait counter.
// -----------------------------------------------------------------------------
package mem_port_arbiter_pkg;

    // Arbiter FSM states; the encoding is fixed so that debug probes and
    // waveform decoders agree across the core.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    // Requester identifiers used for the grant register and round-robin flag.
    localparam logic GRANT_IF = 1'b0;
    localparam logic GRANT_D  = 1'b1;

    // Wait counter width: wait_cycles is limited to 1..15.
    localparam int WAIT_W = 4;

endpackage

// File: rtl/mem_port_arbiter_wait_counter.sv
// -----------------------------------------------------------------------------
// wait_counter
// Counts the memory access cycles of one transaction.
//   clk        : clock, rising edge
//   reset      : synchronous active-high reset, clears the count
//   load       : load load_value (grant cycle)
//   load_value : number of access cycles for the transaction
//   dec        : decrement by one (every ACCESS cycle)
//   last       : high while the count is 1, i.e. the final access cycle
// -----------------------------------------------------------------------------
module wait_counter
    import mem_port_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [WAIT_W-1:0] load_value,
    input  logic              dec,
    output logic              last
);

    logic [WAIT_W-1:0] count;

    // NOTE: sequential state is written with non-blocking assignments only, so
    // every flop samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign last = (count == WAIT_W'(1));

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-port unified memory between the instruction-fetch and
// data ports of the RISC-V core. Transactions run IDLE -> ACCESS (wait_cycles
// cycles) -> RESP (one-cycle ready pulse). Simultaneous requests are resolved
// round-robin; stall freezes the core's PC and IF/ID registers while any
// request is outstanding.
//   clk, reset                  : clock, synchronous active-high reset
//   if_req/if_addr              : fetch request and address
//   if_rdata/if_ready           : fetched word, one-cycle completion pulse
//   d_read/d_write/d_addr/d_wdata : data request (write wins if both set)
//   d_rdata/d_ready             : read data, one-cycle completion pulse
//   mem_addr/mem_wdata/mem_re/mem_we/mem_rdata : memory side
//   stall                       : pipeline freeze request (combinational)
// -----------------------------------------------------------------------------
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int nbits       = 32,
    parameter int wait_cycles = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             if_req,
    input  logic [nbits-1:0] if_addr,
    output logic [nbits-1:0] if_rdata,
    output logic             if_ready,
    input  logic             d_read,
    input  logic             d_write,
    input  logic [nbits-1:0] d_addr,
    input  logic [nbits-1:0] d_wdata,
    output logic [nbits-1:0] d_rdata,
    output logic             d_ready,
    output logic [nbits-1:0] mem_addr,
    output logic [nbits-1:0] mem_wdata,
    output logic             mem_re,
    output logic             mem_we,
    input  logic [nbits-1:0] mem_rdata,
    output logic             stall
);

    arb_state_t       state;
    logic             grant;       // requester owning the current transaction
    logic             last_grant;  // requester that wins the next conflict
    logic [nbits-1:0] rdata;
    logic             d_any;
    logic             any_req;
    logic             next_grant;
    logic             grant_write;
    logic             cnt_load;
    logic             cnt_last;

    assign d_any   = d_read | d_write;
    assign any_req = if_req | d_any;

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path through the block leaves a value held and no latch is inferred.
    always_comb begin
        next_grant  = GRANT_IF;
        grant_write = 1'b0;
        if (if_req && d_any) begin
            next_grant = last_grant;
        end else if (d_any) begin
            next_grant = GRANT_D;
        end
        // A data request with both strobes set is a write; the read is ignored.
        if (next_grant == GRANT_D) begin
            grant_write = d_write;
        end
    end

    assign cnt_load = (state == IDLE) && any_req;

    wait_counter u_wait_counter (
        .clk        (clk),
        .reset      (reset),
        .load       (cnt_load),
        .load_value (WAIT_W'(wait_cycles)),
        .dec        (state == ACCESS),
        .last       (cnt_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            grant      <= GRANT_IF;
            // Reset points the flag at data so the first conflict serves data.
            last_grant <= GRANT_D;
            rdata      <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_re     <= 1'b0;
            mem_we     <= 1'b0;
            if_ready   <= 1'b0;
            d_ready    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if_ready <= 1'b0;
                    d_ready  <= 1'b0;
                    if (any_req) begin
                        state      <= ACCESS;
                        grant      <= next_grant;
                        // The requester just granted yields the next conflict.
                        last_grant <= (next_grant == GRANT_D) ? GRANT_IF : GRANT_D;
                        mem_addr   <= (next_grant == GRANT_D) ? d_addr : if_addr;
                        mem_wdata  <= grant_write ? d_wdata : '0;
                        mem_re     <= ~grant_write;
                        mem_we     <= grant_write;
                    end
                end
                ACCESS: begin
                    if (cnt_last) begin
                        state     <= RESP;
                        rdata     <= mem_rdata;
                        mem_addr  <= '0;
                        mem_wdata <= '0;
                        mem_re    <= 1'b0;
                        mem_we    <= 1'b0;
                        if_ready  <= (grant == GRANT_IF);
                        d_ready   <= (grant == GRANT_D);
                    end
                end
                RESP: begin
                    state    <= IDLE;
                    if_ready <= 1'b0;
                    d_ready  <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    mem_addr  <= '0;
                    mem_wdata <= '0;
                    mem_re    <= 1'b0;
                    mem_we    <= 1'b0;
                    if_ready  <= 1'b0;
                    d_ready   <= 1'b0;
                end
            endcase
        end
    end

    // One capture register serves both ports; it holds between transactions.
    assign if_rdata = rdata;
    assign d_rdata  = rdata;

    assign stall = (if_req & ~if_ready) | (d_any & ~d_ready);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Directed self-checking bench. u_dut3 (wait_cycles=3) carries most scenarios
// with a scoreboard of expected completions; u_dut1 (wait_cycles=1) covers the
// single-cycle fetch case.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam logic [31:0] XOR_KEY = 32'h5A5A_5A5A;

    typedef struct {
        logic        port;   // 0 = fetch, 1 = data
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;

    // wait_cycles = 3 instance
    logic        if_req, d_read, d_write;
    logic [31:0] if_addr, d_addr, d_wdata;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        if_ready, d_ready, mem_re, mem_we, stall;

    // wait_cycles = 1 instance
    logic        if_req_1, d_read_1, d_write_1;
    logic [31:0] if_addr_1, d_addr_1, d_wdata_1;
    logic [31:0] if_rdata_1, d_rdata_1, mem_addr_1, mem_wdata_1, mem_rdata_1;
    logic        if_ready_1, d_ready_1, mem_re_1, mem_we_1, stall_1;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    // Memory model for u_dut3: word = address xor key.
    assign mem_rdata = mem_addr ^ XOR_KEY;

    mem_port_arbiter #(.nbits(32), .wait_cycles(3)) u_dut3 (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_re(mem_re), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .stall(stall)
    );

    mem_port_arbiter #(.nbits(32), .wait_cycles(1)) u_dut1 (
        .clk(clk), .reset(reset),
        .if_req(if_req_1), .if_addr(if_addr_1), .if_rdata(if_rdata_1), .if_ready(if_ready_1),
        .d_read(d_read_1), .d_write(d_write_1), .d_addr(d_addr_1), .d_wdata(d_wdata_1),
        .d_rdata(d_rdata_1), .d_ready(d_ready_1),
        .mem_addr(mem_addr_1), .mem_wdata(mem_wdata_1), .mem_re(mem_re_1), .mem_we(mem_we_1),
        .mem_rdata(mem_rdata_1), .stall(stall_1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for a ready pulse on u_dut3, then pop and compare.
    task automatic serve(input int exp_ticks, input string tag);
        int seen_at = 0;
        for (int i = 1; i <= 12 && seen_at == 0; i++) begin
            tick();
            if (if_ready || d_ready) seen_at = i;
        end
        if (seen_at == 0) begin
            check({tag, "_timeout"}, 32'd0, 32'd1);
        end else if (sb.size() == 0) begin
            check({tag, "_unexpected"}, 32'd1, 32'd0);
        end else begin
            exp_t e;
            e = sb.pop_front();
            check({tag, "_latency"}, 32'(seen_at), 32'(exp_ticks));
            check({tag, "_port"}, {31'd0, d_ready}, {31'd0, e.port});
            check({tag, "_single"}, {31'd0, if_ready & d_ready}, 32'd0);
            check({tag, "_rdata"}, d_ready ? d_rdata : if_rdata, e.data);
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        {if_req, d_read, d_write} = '0;
        {if_addr, d_addr, d_wdata} = '0;
        {if_req_1, d_read_1, d_write_1} = '0;
        {if_addr_1, d_addr_1, d_wdata_1} = '0;
        mem_rdata_1 = '0;
        tick();
        tick();
        reset = 1'b0;

        // ---- reset state ----
        check("rst_mem_re", {31'd0, mem_re}, 32'd0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_ready", {30'd0, if_ready, d_ready}, 32'd0);
        check("rst_rdata", d_rdata, 32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);

        // ---- single-cycle fetch on u_dut1 ----
        if_req_1 = 1'b1;
        if_addr_1 = 32'h0040_0000;
        mem_rdata_1 = 32'h0050_0093;
        #1;
        check("f1_c0_stall", {31'd0, stall_1}, 32'd1);
        tick();
        check("f1_c1_mem_re", {31'd0, mem_re_1}, 32'd1);
        check("f1_c1_addr", mem_addr_1, 32'h0040_0000);
        check("f1_c1_ready", {31'd0, if_ready_1}, 32'd0);
        check("f1_c1_stall", {31'd0, stall_1}, 32'd1);
        tick();
        check("f1_c2_ready", {31'd0, if_ready_1}, 32'd1);
        check("f1_c2_rdata", if_rdata_1, 32'h0050_0093);
        check("f1_c2_mem_re", {31'd0, mem_re_1}, 32'd0);
        check("f1_c2_stall", {31'd0, stall_1}, 32'd0);
        if_req_1 = 1'b0;
        mem_rdata_1 = 32'h1234_5678;
        tick();
        check("f1_c3_ready", {31'd0, if_ready_1}, 32'd0);
        check("f1_c3_hold", if_rdata_1, 32'h0050_0093);

        // ---- three-cycle write ----
        d_write = 1'b1;
        d_addr  = 32'h1001_0004;
        d_wdata = 32'hDEAD_BEEF;
        #1;
        check("wr_c0_stall", {31'd0, stall}, 32'd1);
        for (int c = 1; c <= 3; c++) begin
            tick();
            check($sformatf("wr_c%0d_we", c), {31'd0, mem_we}, 32'd1);
            check($sformatf("wr_c%0d_re", c), {31'd0, mem_re}, 32'd0);
            check($sformatf("wr_c%0d_addr", c), mem_addr, 32'h1001_0004);
            check($sformatf("wr_c%0d_wdata", c), mem_wdata, 32'hDEAD_BEEF);
            check($sformatf("wr_c%0d_ready", c), {31'd0, d_ready}, 32'd0);
        end
        tick();
        check("wr_c4_ready", {31'd0, d_ready}, 32'd1);
        check("wr_c4_we", {31'd0, mem_we}, 32'd0);
        check("wr_c4_addr", mem_addr, 32'd0);
        check("wr_c4_stall", {31'd0, stall}, 32'd0);
        d_write = 1'b0;
        tick();
        check("wr_c5_ready", {31'd0, d_ready}, 32'd0);

        // ---- read and write together: treated as write ----
        d_read  = 1'b1;
        d_write = 1'b1;
        d_addr  = 32'h1001_0010;
        d_wdata = 32'h0BAD_F00D;
        for (int c = 1; c <= 3; c++) begin
            tick();
            check($sformatf("rw_c%0d_we", c), {31'd0, mem_we}, 32'd1);
            check($sformatf("rw_c%0d_re", c), {31'd0, mem_re}, 32'd0);
        end
        tick();
        check("rw_ready", {31'd0, d_ready}, 32'd1);
        {d_read, d_write} = 2'b00;
        tick();

        // ---- conflicts from reset: data, fetch, data ----
        pulse_reset();
        if_req = 1'b1;
        if_addr = 32'h0040_0100;
        d_read = 1'b1;
        d_addr = 32'h1001_0020;
        sb.push_back('{port: 1'b1, data: 32'h1001_0020 ^ XOR_KEY});
        sb.push_back('{port: 1'b0, data: 32'h0040_0100 ^ XOR_KEY});
        sb.push_back('{port: 1'b1, data: 32'h1001_0020 ^ XOR_KEY});
        serve(4, "rr0");
        serve(5, "rr1");
        serve(5, "rr2");
        {if_req, d_read} = 2'b00;
        tick();

        // ---- fetch request dropped after cycle 0 ----
        if_req  = 1'b1;
        if_addr = 32'h0040_0200;
        sb.push_back('{port: 1'b0, data: 32'h0040_0200 ^ XOR_KEY});
        tick();
        if_req = 1'b0;
        #1;
        check("drop_c1_stall", {31'd0, stall}, 32'd0);
        check("drop_c1_re", {31'd0, mem_re}, 32'd1);
        serve(3, "drop");
        check("drop_stall", {31'd0, stall}, 32'd0);
        tick();

        // ---- reset in the second ACCESS cycle aborts the write ----
        d_write = 1'b1;
        d_addr  = 32'h1001_0030;
        d_wdata = 32'h5555_AAAA;
        tick();
        tick();
        check("abort_c2_we", {31'd0, mem_we}, 32'd1);
        reset   = 1'b1;
        d_write = 1'b0;
        tick();
        reset = 1'b0;
        check("abort_we", {31'd0, mem_we}, 32'd0);
        check("abort_re", {31'd0, mem_re}, 32'd0);
        check("abort_ready", {31'd0, d_ready}, 32'd0);
        for (int c = 0; c < 4; c++) begin
            tick();
            check($sformatf("abort_quiet%0d", c), {30'd0, d_ready, mem_we}, 32'd0);
        end
        // Back in IDLE: a fresh fetch completes with the nominal latency.
        if_req  = 1'b1;
        if_addr = 32'h0040_0300;
        sb.push_back('{port: 1'b0, data: 32'h0040_0300 ^ XOR_KEY});
        serve(4, "post_abort");
        if_req = 1'b0;
        tick();

        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
